ir_prefetch: RTL and testbench

//   Instruction fetch/prefetch stage directly upstream of the control unit. Fetches 32-bit

---
 rtl/cu_pkg.sv | 18 +
 rtl/ir_prefetch_fifo.sv | 65 ++++++
 rtl/ir_prefetch.sv | 125 ++++++++++++
 tb/tb_ir_prefetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared control-unit types: instruction register word and fetch states
package cu_pkg;

    typedef struct packed {
        logic [3:0]  cond;
        logic [11:0] instruction;
        logic [15:0] params;
    } ir_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DISCARD
    } fetch_state_e;

    localparam int IR_W = $bits(ir_t);

endpackage

// File: rtl/ir_prefetch_fifo.sv
// rtl/ir_prefetch_fifo.sv - DEPTH-entry FIFO of instruction words with their fetch addresses
module ir_fifo
    import cu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  ir_t               push_ir,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              clear,
    output ir_t               head_ir,
    output logic [ADDR_W-1:0] head_addr,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    ir_t               ir_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    end

    assign head_ir   = ir_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];

    // Storage is zeroed only on reset so the head reads 0 before any fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem[i]   <= '0;
                addr_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                ir_mem[wr_ptr]   <= push_ir;
                addr_mem[wr_ptr] <= push_addr;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ir_prefetch.sv
// rtl/ir_prefetch.sv - instruction prefetch stage: memory fetch FSM, buffer, redirect with discard
module ir_prefetch
    import cu_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic              ir_valid,
    output ir_t               ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic              ack;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic              slot_free;
    logic              slot_after_push;

    always_comb begin
        ack             = mem_req && mem_ack;
        pop             = ir_valid && ir_ready && !pc_load;
        push            = (state == FETCH_WAIT) && ack && !pc_load;
        cnt_after_pop   = count - CNT_W'(pop);
        slot_free       = cnt_after_pop < CNT_W'(DEPTH);
        slot_after_push = (cnt_after_pop + CNT_W'(1)) < CNT_W'(DEPTH);
    end

    assign ir_valid = (count != '0);

    ir_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_ir   (ir_t'(mem_data)),
        .push_addr (mem_addr),
        .pop       (pop),
        .clear     (pc_load),
        .head_ir   (ir),
        .head_addr (ir_pc),
        .count     (count)
    );

    // A redirect never aborts a pending request; the memory must still see it completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (pc_load) begin
                        fetch_pc <= pc_load_value;
                    end else if (slot_free) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (pc_load) begin
                        fetch_pc <= pc_load_value;
                        if (ack) begin
                            mem_req <= 1'b0;
                            state   <= FETCH_IDLE;
                        end else begin
                            state <= FETCH_DISCARD;
                        end
                    end else if (ack) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        if (slot_after_push) begin
                            mem_addr <= fetch_pc + ADDR_W'(1);
                        end else begin
                            mem_req <= 1'b0;
                            state   <= FETCH_IDLE;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (pc_load) begin
                        fetch_pc <= pc_load_value;
                        if (ack) begin
                            mem_req <= 1'b0;
                            state   <= FETCH_IDLE;
                        end
                    end else if (ack) begin
                        if (slot_free) begin
                            mem_addr <= fetch_pc;
                            state    <= FETCH_WAIT;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= FETCH_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_prefetch.sv
// tb/tb_ir_prefetch.sv - scoreboard bench for ir_prefetch with a responding memory model
module tb_ir_prefetch;
    import cu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        ir_valid;
    ir_t         ir;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = '0;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];
    logic [15:0] exp_addr;
    bit          auto_ack, force_ack, beef, discarding, pop_now, acked;
    logic [47:0] pop_word;

    always #5 clk = ~clk;

    ir_prefetch #(.DEPTH(2), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .ir_valid      (ir_valid),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value)
    );

    // One clock: memory responds, model predicts, head snapshot taken before the edge.
    task automatic step();
        @(negedge clk);
        mem_ack = 1'b0;
        acked   = 1'b0;
        if (mem_req && (auto_ack || force_ack)) begin
            mem_ack  = 1'b1;
            acked    = 1'b1;
            mem_data = beef ? 32'hDEAD_BEEF : ({16'h0, mem_addr} + 32'h1000_0000);
            if (!pc_load && !discarding) begin
                exp_q.push_back({({16'h0, exp_addr} + 32'h1000_0000), exp_addr});
                exp_addr = exp_addr + 16'd1;
            end
            discarding = 1'b0;
        end else if (pc_load && mem_req) begin
            discarding = 1'b1;
        end
        pop_now  = ir_valid && ir_ready && !pc_load;
        pop_word = {ir, ir_pc};
        if (pc_load) begin
            exp_q.delete();
            exp_addr = pc_load_value;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b0; mem_data = '0; ir_ready = 1'b0;
        pc_load = 1'b0; pc_load_value = '0;
        auto_ack = 1'b0; force_ack = 1'b0; beef = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_addr = 16'h0000;
        discarding = 1'b0;
    endtask

    task automatic test_reset();
        auto_ack = 1'b0; force_ack = 1'b0; beef = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, ir_valid, ir, ir_pc} !== '0) begin
            errors++;
            $display("FAIL reset_state got req=%b addr=%h v=%b ir=%h pc=%h want all 0",
                     mem_req, mem_addr, ir_valid, ir, ir_pc);
        end
        rst_n = 1'b1;
        exp_q.delete(); exp_addr = 16'h0000; discarding = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h want 1 0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_stream();
        int  pops = 0;
        bit  seen = 1'b0;
        bit  gap = 1'b0;
        ir_ready = 1'b1; auto_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop_now) begin
                checks++; pops++;
                if (exp_q.size() == 0 || pop_word !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream_pop got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
            end
            if (seen && !ir_valid) gap = 1'b1;
            if (ir_valid) seen = 1'b1;
        end
        checks++;
        if (pops != 19 || gap) begin
            errors++;
            $display("FAIL stream_rate got pops=%0d gap=%b want 19 0", pops, gap);
        end
    endtask

    task automatic test_full();
        int acks = 0;
        do_reset();
        auto_ack = 1'b1; ir_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); acks += acked; end
        checks++;
        if (acks != 2 || mem_req !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 16'h0000) begin
            errors++;
            $display("FAIL full_stop got acks=%0d req=%b v=%b pc=%h want 2 0 1 0000",
                     acks, mem_req, ir_valid, ir_pc);
        end
        ir_ready = 1'b1;
        step(); acks += acked;
        if (pop_now) begin
            checks++;
            if (exp_q.size() == 0 || pop_word !== exp_q[0]) begin
                errors++;
                $display("FAIL full_pop got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
            end
            if (exp_q.size() != 0) exp_q.delete(0);
        end
        ir_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL full_refill got req=%b addr=%h want 1 0002", mem_req, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin step(); acks += acked; end
        checks++;
        if (acks != 3 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_again got acks=%0d req=%b want 3 0", acks, mem_req);
        end
        ir_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pop_now) begin
                checks++;
                if (exp_q.size() == 0 || pop_word !== exp_q[0]) begin
                    errors++;
                    $display("FAIL full_drain got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
            end
        end
    endtask

    task automatic test_redirect();
        bit first = 1'b1;
        do_reset();
        auto_ack = 1'b0; ir_ready = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL redir_timeout got req=%b want 1", mem_req);
        end
        pc_load = 1'b1; pc_load_value = 16'h0040;
        step();
        pc_load = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL redir_hold got req=%b addr=%h want 1 0000", mem_req, mem_addr);
        end
        step(); step();
        force_ack = 1'b1; beef = 1'b1;
        step();
        force_ack = 1'b0; beef = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL redir_discard got v=%b req=%b addr=%h want 0 1 0040", ir_valid, mem_req, mem_addr);
        end
        auto_ack = 1'b1; ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pop_now) begin
                checks++;
                if (exp_q.size() == 0 || pop_word !== exp_q[0] || (first && pop_word[15:0] !== 16'h0040)) begin
                    errors++;
                    $display("FAIL redir_pop got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
                first = 1'b0;
            end
        end
    endtask

    task automatic test_load_ack_pop();
        do_reset();
        auto_ack = 1'b1; ir_ready = 1'b0;
        for (int i = 0; i < 10 && !ir_valid; i++) step();
        ir_ready = 1'b1; pc_load = 1'b1; pc_load_value = 16'h0080;
        step();
        pc_load = 1'b0; ir_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL lap_flush got v=%b req=%b want 0 0", ir_valid, mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0080) begin
            errors++;
            $display("FAIL lap_refetch got req=%b addr=%h want 1 0080", mem_req, mem_addr);
        end
        ir_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pop_now) begin
                checks++;
                if (exp_q.size() == 0 || pop_word !== exp_q[0]) begin
                    errors++;
                    $display("FAIL lap_pop got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] pcs[$];
        do_reset();
        auto_ack = 1'b1; ir_ready = 1'b1;
        pc_load = 1'b1; pc_load_value = 16'hFFFF;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (pop_now) begin
                checks++;
                pcs.push_back(pop_word[15:0]);
                if (exp_q.size() == 0 || pop_word !== exp_q[0]) begin
                    errors++;
                    $display("FAIL wrap_pop got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
            end
        end
        checks++;
        if (pcs.size() < 3 || pcs[0] !== 16'hFFFF || pcs[1] !== 16'h0000 || pcs[2] !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_seq got n=%0d %h %h %h want FFFF 0000 0001", pcs.size(),
                     pcs.size() > 0 ? pcs[0] : 16'hx, pcs.size() > 1 ? pcs[1] : 16'hx,
                     pcs.size() > 2 ? pcs[2] : 16'hx);
        end
    endtask

    task automatic test_reset_mid();
        bit first = 1'b1;
        do_reset();
        auto_ack = 1'b1; ir_ready = 1'b0;
        for (int i = 0; i < 10 && !ir_valid; i++) step();
        auto_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async got req=%b v=%b addr=%h want 0 0 0000", mem_req, ir_valid, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); exp_addr = 16'h0000; discarding = 1'b0;
        auto_ack = 1'b1; ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pop_now) begin
                checks++;
                if (exp_q.size() == 0 || pop_word !== exp_q[0] || (first && pop_word[15:0] !== 16'h0000)) begin
                    errors++;
                    $display("FAIL rst_refetch got %h want %h", pop_word, exp_q.size() ? exp_q[0] : 48'hx);
                end
                if (exp_q.size() != 0) exp_q.delete(0);
                first = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_load_ack_pop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
